// File: rtl/inst_fetch_mem.sv
// Instruction memory with a valid/ready fetch port, a loader write port and a RUN/LOAD/FLUSH mode FSM.
// Optional per-word even parity is enabled by defining IMEM_PARITY_EN.
module inst_fetch_mem #(
  parameter int                ADDR_W   = 20,
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 16384,
  parameter logic [DATA_W-1:0] NOP_WORD = 32'h00000013
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_ready,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] fetch_data,
  output logic              fetch_err,
  output logic [1:0]        err_code,
  input  logic              load_en,
  input  logic              load_we,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic              busy
);

  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic [1:0] {ST_RUN, ST_LOAD, ST_FLUSH} state_t;
  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_MISALIGN = 2'b01,
    ERR_RANGE    = 2'b10,
    ERR_PARITY   = 2'b11
  } err_code_t;

  state_t            state_q, state_d;
  logic              resp_valid_q;
  err_code_t         addr_code_q;
  logic [DATA_W-1:0] ram_q;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              accept;
  logic              fetch_misalign, fetch_oob, rd_en;
  logic              load_oob, load_wr;
  logic [IDX_W-1:0]  fetch_idx, load_idx;

  assign fetch_misalign = (fetch_addr[1:0] != 2'b00);
  assign fetch_oob      = (32'(fetch_addr[ADDR_W-1:2]) >= 32'(DEPTH));
  assign fetch_idx      = fetch_addr[IDX_W+1:2];
  assign load_oob       = (32'(load_addr[ADDR_W-1:2]) >= 32'(DEPTH));
  assign load_idx       = load_addr[IDX_W+1:2];

  assign fetch_ready = (state_q == ST_RUN) && !load_en && (!resp_valid_q || resp_ready);
  assign accept      = fetch_req && fetch_ready;
  assign rd_en       = accept && !fetch_misalign && !fetch_oob;
  assign load_wr     = (state_q == ST_LOAD) && load_we && !load_oob;
  assign busy        = (state_q != ST_RUN);
  assign resp_valid  = resp_valid_q;

  // Mode FSM: LOAD hands the RAM to the loader, FLUSH is a one-cycle fence before fetch resumes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_RUN;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN:   if (load_en)  state_d = ST_LOAD;
      ST_LOAD:  if (!load_en) state_d = ST_FLUSH;
      ST_FLUSH: state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  // NOTE: RAM array and its read register carry no reset so they map onto block RAM;
  // ram_q only changes on an accept, so it doubles as the response hold register.
  always_ff @(posedge clk) begin
    if (load_wr) mem[load_idx] <= load_data;
    if (rd_en)   ram_q <= mem[fetch_idx];
  end

`ifdef IMEM_PARITY_EN
  logic par_mem [DEPTH];
  logic par_q;

  always_ff @(posedge clk) begin
    if (load_wr) par_mem[load_idx] <= ^load_data;
    if (rd_en)   par_q <= par_mem[fetch_idx];
  end
`endif

  // Response control: address errors are decided at accept; misaligned outranks out of range.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid_q <= 1'b0;
      addr_code_q  <= ERR_NONE;
    end else if (accept) begin
      resp_valid_q <= 1'b1;
      if (fetch_misalign)  addr_code_q <= ERR_MISALIGN;
      else if (fetch_oob)  addr_code_q <= ERR_RANGE;
      else                 addr_code_q <= ERR_NONE;
    end else if (resp_ready) begin
      resp_valid_q <= 1'b0;
    end
  end

  // Outputs read as zero with no response pending, which also gives the reset values.
  always_comb begin
    err_code_t code;
    code       = ERR_NONE;
    fetch_err  = 1'b0;
    fetch_data = '0;
    err_code   = 2'b00;
    if (resp_valid_q) begin
      code = addr_code_q;
`ifdef IMEM_PARITY_EN
      if (code == ERR_NONE && (^{ram_q, par_q})) code = ERR_PARITY;
`endif
      fetch_err  = (code != ERR_NONE);
      fetch_data = fetch_err ? NOP_WORD : ram_q;
      err_code   = code;
    end
  end

endmodule
